// File: rtl/mips_core_pkg.sv
// Shared core types: active list geometry, entry payload and the FSM encoding.
package mips_core_pkg;

  localparam int unsigned ADDR_WIDTH        = 8;
  localparam int unsigned ACTIVE_LIST_DEPTH = 32;
  localparam int unsigned AL_IDX_W          = 5;
  localparam int unsigned AL_PTR_W          = 6;
  localparam int unsigned PHYS_W            = 6;

  typedef logic [AL_IDX_W-1:0] ActiveListIndex;
  typedef logic [AL_PTR_W-1:0] ActiveListPtr;
  typedef logic [PHYS_W-1:0]   PhysReg;

  typedef enum logic [1:0] {
    AL_NORMAL   = 2'd0,
    AL_ROLLBACK = 2'd1,
    AL_DONE     = 2'd2
  } ActiveListState;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] id;
    logic                  uses_rw;
    PhysReg                new_phys;
    PhysReg                old_phys;
  } ActiveListEntry;

  // True when slot a was allocated before slot b; distance is taken from head so wrap is harmless.
  function automatic logic al_is_older(ActiveListIndex a, ActiveListIndex b, ActiveListIndex head);
    ActiveListIndex age_a;
    ActiveListIndex age_b;
    age_a = a - head;
    age_b = b - head;
    return age_a < age_b;
  endfunction

endpackage

// File: rtl/active_list.sv
// 32-entry reorder buffer: in-order commit of old mappings, tail-side rollback of
// squashed new mappings after a mispredict, with a flush / flush_done handshake.
module active_list
  import mips_core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [ADDR_WIDTH-1:0] alloc_instruction_ID,
  input  logic                  alloc_uses_rw,
  input  logic [PHYS_W-1:0]     alloc_new_phys,
  input  logic [PHYS_W-1:0]     alloc_old_phys,
  output logic [AL_IDX_W-1:0]   alloc_index,
  input  logic                  complete_valid,
  input  logic [AL_IDX_W-1:0]   complete_index,
  input  logic                  complete_mispredict,
  output logic                  commit_valid,
  output logic [PHYS_W-1:0]     commit_free_phys,
  output logic                  commit_uses_rw,
  output logic [ADDR_WIDTH-1:0] commit_instruction_ID,
  output logic                  rollback_valid,
  output logic [PHYS_W-1:0]     rollback_phys,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] flushed_instruction_ID,
  output logic                  flush_done,
  output logic [AL_PTR_W-1:0]   count
);

  localparam int unsigned DEPTH = ACTIVE_LIST_DEPTH;

  ActiveListState   state;
  ActiveListState   state_next;
  ActiveListPtr     head_ptr;
  ActiveListPtr     tail_ptr;
  ActiveListPtr     head_next;
  ActiveListPtr     tail_next;
  ActiveListIndex   head_idx;
  ActiveListIndex   tail_idx;
  ActiveListIndex   tail_last_idx;
  ActiveListIndex   flush_point;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  ActiveListEntry   entries [DEPTH];

  logic do_alloc;
  logic do_commit;
  logic do_rollback;
  logic rollback_end;
  logic commit_block;
  logic mispredict_older;
  logic mispredict_hit;

  assign head_idx      = head_ptr[AL_IDX_W-1:0];
  assign tail_idx      = tail_ptr[AL_IDX_W-1:0];
  assign tail_last_idx = tail_idx - AL_IDX_W'(1);
  assign alloc_index   = tail_idx;
  assign alloc_ready   = (count < AL_PTR_W'(DEPTH)) && (state == AL_NORMAL);

  // Per-cycle datapath decisions and next pointers.
  always_comb begin
    do_alloc         = alloc_valid && alloc_ready;
    // Once the flush point itself has retired, head sits on squashed slots.
    commit_block     = (state == AL_ROLLBACK) && !valid_q[flush_point];
    do_commit        = valid_q[head_idx] && done_q[head_idx] && !commit_block;
    rollback_end     = (tail_last_idx == flush_point);
    do_rollback      = (state == AL_ROLLBACK) && !rollback_end;
    mispredict_older = al_is_older(complete_index, flush_point, head_idx);
    mispredict_hit   = complete_valid && complete_mispredict && valid_q[complete_index] &&
                       ((state != AL_ROLLBACK) || mispredict_older);
    head_next        = head_ptr + AL_PTR_W'(do_commit);
    tail_next        = tail_ptr;
    if (do_alloc) begin
      tail_next = tail_ptr + AL_PTR_W'(1);
    end else if (do_rollback) begin
      tail_next = tail_ptr - AL_PTR_W'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      AL_NORMAL: begin
        if (mispredict_hit) state_next = AL_ROLLBACK;
      end
      AL_ROLLBACK: begin
        if (rollback_end && !mispredict_hit) state_next = AL_DONE;
      end
      AL_DONE: begin
        state_next = mispredict_hit ? AL_ROLLBACK : AL_NORMAL;
      end
      default: state_next = AL_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= AL_NORMAL;
    end else begin
      state <= state_next;
    end
  end

  // Pointers, status bits and registered output ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr               <= '0;
      tail_ptr               <= '0;
      count                  <= '0;
      valid_q                <= '0;
      done_q                 <= '0;
      flush_point            <= '0;
      commit_valid           <= 1'b0;
      commit_free_phys       <= '0;
      commit_uses_rw         <= 1'b0;
      commit_instruction_ID  <= '0;
      rollback_valid         <= 1'b0;
      rollback_phys          <= '0;
      flush                  <= 1'b0;
      flush_done             <= 1'b0;
      flushed_instruction_ID <= '0;
    end else begin
      head_ptr <= head_next;
      tail_ptr <= tail_next;
      count    <= tail_next - head_next;

      if (complete_valid && valid_q[complete_index]) begin
        done_q[complete_index] <= 1'b1;
      end
      if (do_alloc) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
      end
      if (do_commit) begin
        valid_q[head_idx] <= 1'b0;
        done_q[head_idx]  <= 1'b0;
      end
      if (do_rollback) begin
        valid_q[tail_last_idx] <= 1'b0;
        done_q[tail_last_idx]  <= 1'b0;
      end

      commit_valid <= do_commit;
      if (do_commit) begin
        commit_free_phys      <= entries[head_idx].old_phys;
        commit_uses_rw        <= entries[head_idx].uses_rw;
        commit_instruction_ID <= entries[head_idx].id;
      end

      rollback_valid <= do_rollback && entries[tail_last_idx].uses_rw;
      if (do_rollback) begin
        rollback_phys <= entries[tail_last_idx].new_phys;
      end

      if (mispredict_hit) begin
        flush_point            <= complete_index;
        flushed_instruction_ID <= entries[complete_index].id;
      end

      flush      <= (state_next == AL_ROLLBACK);
      flush_done <= (state_next == AL_DONE);
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      entries[tail_idx] <= '{id:       alloc_instruction_ID,
                             uses_rw:  alloc_uses_rw,
                             new_phys: alloc_new_phys,
                             old_phys: alloc_old_phys};
    end
  end

endmodule

// File: tb/tb_active_list.sv
// Directed bench for active_list: a per-cycle vector table plus hand-written
// fill, rollback, nested-rollback, wrap and reset-during-rollback sequences.
module tb_active_list;
  import mips_core_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [ADDR_WIDTH-1:0] alloc_instruction_ID;
  logic                  alloc_uses_rw;
  logic [PHYS_W-1:0]     alloc_new_phys;
  logic [PHYS_W-1:0]     alloc_old_phys;
  logic [AL_IDX_W-1:0]   alloc_index;
  logic                  complete_valid;
  logic [AL_IDX_W-1:0]   complete_index;
  logic                  complete_mispredict;
  logic                  commit_valid;
  logic [PHYS_W-1:0]     commit_free_phys;
  logic                  commit_uses_rw;
  logic [ADDR_WIDTH-1:0] commit_instruction_ID;
  logic                  rollback_valid;
  logic [PHYS_W-1:0]     rollback_phys;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] flushed_instruction_ID;
  logic                  flush_done;
  logic [AL_PTR_W-1:0]   count;

  active_list dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_instruction_ID(alloc_instruction_ID), .alloc_uses_rw(alloc_uses_rw),
    .alloc_new_phys(alloc_new_phys), .alloc_old_phys(alloc_old_phys),
    .alloc_index(alloc_index),
    .complete_valid(complete_valid), .complete_index(complete_index),
    .complete_mispredict(complete_mispredict),
    .commit_valid(commit_valid), .commit_free_phys(commit_free_phys),
    .commit_uses_rw(commit_uses_rw), .commit_instruction_ID(commit_instruction_ID),
    .rollback_valid(rollback_valid), .rollback_phys(rollback_phys),
    .flush(flush), .flushed_instruction_ID(flushed_instruction_ID),
    .flush_done(flush_done), .count(count)
  );

  always #5 clk = ~clk;

  // Inputs applied for one cycle, then outputs expected just after that edge.
  typedef struct {
    int rst; int av; int aid; int auw; int anew; int aold; int cv; int ci; int cm;
    int e_ready; int e_idx; int e_cv; int e_cphys; int e_cuw; int e_cid;
    int e_rbv; int e_flush; int e_fid; int e_fdone; int e_count;
  } vec_t;

  vec_t vecs [21];
  int n_cmp = 0;
  int n_bad = 0;
  logic [PHYS_W-1:0] rb_seen [$];
  int flush_cycles;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic uw_of(input int id);
    return (id % 3) != 2;
  endfunction

  function automatic logic [PHYS_W-1:0] new_of(input int id);
    return PHYS_W'(id + 8);
  endfunction

  function automatic logic [PHYS_W-1:0] old_of(input int id);
    return PHYS_W'(id + 40);
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; alloc_valid = 1'b0; complete_valid = 1'b0; complete_mispredict = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
  endtask

  task automatic set_alloc(input int id);
    alloc_valid          = 1'b1;
    alloc_instruction_ID = ADDR_WIDTH'(id);
    alloc_uses_rw        = uw_of(id);
    alloc_new_phys       = new_of(id);
    alloc_old_phys       = old_of(id);
  endtask

  task automatic alloc_one(input int id);
    set_alloc(id);
    step();
  endtask

  task automatic set_complete(input int idx, input logic mp);
    complete_valid      = 1'b1;
    complete_index      = AL_IDX_W'(idx);
    complete_mispredict = mp;
  endtask

  task automatic fill(input int n);
    do_reset();
    for (int i = 0; i < n; i++) alloc_one(i);
  endtask

  // Walk the rollback until flush_done, recording returned registers.
  task automatic collect_rollback(input int bound);
    int got_done;
    got_done = 0;
    rb_seen.delete();
    flush_cycles = 0;
    for (int k = 0; k < bound; k++) begin
      if (flush) flush_cycles++;
      if (rollback_valid) rb_seen.push_back(rollback_phys);
      if (flush_done) begin
        got_done = 1;
        break;
      end
      step();
    end
    chk("flush_done_seen", got_done, 1);
  endtask

  task automatic check_rb(input string name, input int hi, input int lo);
    logic [PHYS_W-1:0] exp_q [$];
    for (int id = hi; id >= lo; id--) if (uw_of(id)) exp_q.push_back(new_of(id));
    chk({name, "_len"}, rb_seen.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rb_seen.size(); i++)
      chk({name, "_phys"}, int'(rb_seen[i]), int'(exp_q[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int got;
    int exp_ids [4];
    idle_inputs();
    alloc_instruction_ID = '0; alloc_uses_rw = 1'b0; alloc_new_phys = '0; alloc_old_phys = '0;
    complete_index = '0;

    //          rst av aid auw anew aold cv ci cm | rdy idx cv cphys cuw cid rbv fl fid fd cnt
    vecs[0]  = '{1, 0, 0, 0,  0,  0, 0, 0, 0,   1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 1, 10, 40, 0, 0, 0,   1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 1};
    vecs[2]  = '{0, 1, 1, 1, 11, 41, 0, 0, 0,   1, 2, 0,  0, 0, 0, 0, 0, 0, 0, 2};
    vecs[3]  = '{0, 1, 2, 0, 12, 42, 0, 0, 0,   1, 3, 0,  0, 0, 0, 0, 0, 0, 0, 3};
    vecs[4]  = '{0, 0, 0, 0,  0,  0, 1, 1, 0,   1, 3, 0,  0, 0, 0, 0, 0, 0, 0, 3};
    vecs[5]  = '{0, 0, 0, 0,  0,  0, 1, 0, 0,   1, 3, 0,  0, 0, 0, 0, 0, 0, 0, 3};
    vecs[6]  = '{0, 0, 0, 0,  0,  0, 0, 0, 0,   1, 3, 1, 40, 1, 0, 0, 0, 0, 0, 2};
    vecs[7]  = '{0, 0, 0, 0,  0,  0, 0, 0, 0,   1, 3, 1, 41, 1, 1, 0, 0, 0, 0, 1};
    vecs[8]  = '{0, 0, 0, 0,  0,  0, 0, 0, 0,   1, 3, 0,  0, 0, 0, 0, 0, 0, 0, 1};
    vecs[9]  = '{0, 0, 0, 0,  0,  0, 1, 2, 0,   1, 3, 0,  0, 0, 0, 0, 0, 0, 0, 1};
    vecs[10] = '{0, 0, 0, 0,  0,  0, 0, 0, 0,   1, 3, 1, 42, 0, 2, 0, 0, 0, 0, 0};
    vecs[11] = '{0, 1, 3, 1, 13, 43, 1, 3, 0,   1, 4, 0,  0, 0, 0, 0, 0, 0, 0, 1};
    vecs[12] = '{0, 0, 0, 0,  0,  0, 0, 0, 0,   1, 4, 0,  0, 0, 0, 0, 0, 0, 0, 1};
    vecs[13] = '{0, 0, 0, 0,  0,  0, 1, 3, 0,   1, 4, 0,  0, 0, 0, 0, 0, 0, 0, 1};
    vecs[14] = '{0, 1, 4, 1, 14, 44, 0, 0, 0,   1, 5, 1, 43, 1, 3, 0, 0, 0, 0, 1};
    vecs[15] = '{0, 0, 0, 0,  0,  0, 1, 4, 0,   1, 5, 0,  0, 0, 0, 0, 0, 0, 0, 1};
    vecs[16] = '{0, 0, 0, 0,  0,  0, 0, 0, 0,   1, 5, 1, 44, 1, 4, 0, 0, 0, 0, 0};
    vecs[17] = '{0, 1, 5, 1, 15, 45, 0, 0, 0,   1, 6, 0,  0, 0, 0, 0, 0, 0, 0, 1};
    vecs[18] = '{0, 0, 0, 0,  0,  0, 1, 5, 1,   0, 6, 0,  0, 0, 0, 0, 1, 5, 0, 1};
    vecs[19] = '{0, 0, 0, 0,  0,  0, 0, 0, 0,   0, 6, 1, 45, 1, 5, 0, 0, 5, 1, 0};
    vecs[20] = '{0, 0, 0, 0,  0,  0, 0, 0, 0,   1, 6, 0,  0, 0, 0, 0, 0, 5, 0, 0};

    for (int i = 0; i < 21; i++) begin
      rst                  = 1'(vecs[i].rst);
      alloc_valid          = 1'(vecs[i].av);
      alloc_instruction_ID = ADDR_WIDTH'(vecs[i].aid);
      alloc_uses_rw        = 1'(vecs[i].auw);
      alloc_new_phys       = PHYS_W'(vecs[i].anew);
      alloc_old_phys       = PHYS_W'(vecs[i].aold);
      complete_valid       = 1'(vecs[i].cv);
      complete_index       = AL_IDX_W'(vecs[i].ci);
      complete_mispredict  = 1'(vecs[i].cm);
      step();
      chk($sformatf("v%0d_ready", i), int'(alloc_ready), vecs[i].e_ready);
      chk($sformatf("v%0d_index", i), int'(alloc_index), vecs[i].e_idx);
      chk($sformatf("v%0d_commit_valid", i), int'(commit_valid), vecs[i].e_cv);
      chk($sformatf("v%0d_rollback_valid", i), int'(rollback_valid), vecs[i].e_rbv);
      chk($sformatf("v%0d_flush", i), int'(flush), vecs[i].e_flush);
      chk($sformatf("v%0d_flushed_id", i), int'(flushed_instruction_ID), vecs[i].e_fid);
      chk($sformatf("v%0d_flush_done", i), int'(flush_done), vecs[i].e_fdone);
      chk($sformatf("v%0d_count", i), int'(count), vecs[i].e_count);
      if (vecs[i].e_cv != 0) begin
        chk($sformatf("v%0d_commit_phys", i), int'(commit_free_phys), vecs[i].e_cphys);
        chk($sformatf("v%0d_commit_uses_rw", i), int'(commit_uses_rw), vecs[i].e_cuw);
        chk($sformatf("v%0d_commit_id", i), int'(commit_instruction_ID), vecs[i].e_cid);
      end
    end

    // Full list: commit frees a slot but the same-cycle alloc stays blocked.
    fill(32);
    chk("full_ready", int'(alloc_ready), 0);
    chk("full_count", int'(count), 32);
    set_alloc(32); set_complete(0, 1'b0);
    step();
    chk("full_c1_count", int'(count), 32);
    chk("full_c1_commit", int'(commit_valid), 0);
    set_alloc(32);
    step();
    chk("full_c2_commit", int'(commit_valid), 1);
    chk("full_c2_commit_id", int'(commit_instruction_ID), 0);
    chk("full_c2_count", int'(count), 31);
    chk("full_c2_ready", int'(alloc_ready), 1);
    chk("full_c2_index", int'(alloc_index), 0);
    set_alloc(32);
    step();
    chk("full_c3_count", int'(count), 32);
    chk("full_c3_index", int'(alloc_index), 1);

    // Mispredict at slot 4 of 10: squash 9..5 from the tail.
    fill(10);
    set_complete(4, 1'b1);
    step();
    chk("rb_flush_start", int'(flush), 1);
    chk("rb_flushed_id", int'(flushed_instruction_ID), 4);
    chk("rb_ready_low", int'(alloc_ready), 0);
    collect_rollback(20);
    chk("rb_flush_cycles", flush_cycles, 6);
    check_rb("rb", 9, 5);
    chk("rb_tail", int'(alloc_index), 5);
    chk("rb_count", int'(count), 5);
    chk("rb_done_flush_low", int'(flush), 0);
    step();
    chk("rb_done_pulse_end", int'(flush_done), 0);
    chk("rb_ready_back", int'(alloc_ready), 1);

    // Older mispredict mid-rollback moves the flush point; a younger one does not.
    fill(10);
    set_complete(4, 1'b1);
    step();
    chk("nest_fid_first", int'(flushed_instruction_ID), 4);
    set_complete(2, 1'b1);
    step();
    chk("nest_fid_moved", int'(flushed_instruction_ID), 2);
    set_complete(3, 1'b1);
    collect_rollback(20);
    check_rb("nest_rb", 9, 3);
    chk("nest_fid_kept", int'(flushed_instruction_ID), 2);
    chk("nest_tail", int'(alloc_index), 3);
    chk("nest_count", int'(count), 3);

    // Wrap: drain to head=30, then allocate across the index boundary.
    fill(30);
    for (int i = 0; i < 30; i++) begin
      set_complete(i, 1'b0);
      step();
    end
    for (int k = 0; k < 40 && count != 0; k++) step();
    chk("wrap_drained", int'(count), 0);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("wrap_index%0d", j), int'(alloc_index), (30 + j) % 32);
      exp_ids[j] = 100 + j;
      alloc_one(100 + j);
    end
    set_complete(1, 1'b0);  step();
    set_complete(0, 1'b0);  step();
    set_complete(31, 1'b0); step();
    set_complete(30, 1'b0); step();
    got = 0;
    for (int k = 0; k < 20 && got < 4; k++) begin
      step();
      if (commit_valid) begin
        chk($sformatf("wrap_commit_id%0d", got), int'(commit_instruction_ID), exp_ids[got]);
        chk($sformatf("wrap_commit_phys%0d", got), int'(commit_free_phys), int'(old_of(exp_ids[got])));
        got++;
      end
    end
    chk("wrap_commits", got, 4);
    chk("wrap_count", int'(count), 0);
    chk("wrap_tail", int'(alloc_index), 2);

    // Reset in the middle of a rollback.
    fill(10);
    set_complete(2, 1'b1);
    step();
    step();
    chk("rst_mid_in_rollback", int'(flush), 1);
    rst = 1'b1;
    step();
    chk("rst_commit_valid", int'(commit_valid), 0);
    chk("rst_commit_id", int'(commit_instruction_ID), 0);
    chk("rst_rollback_valid", int'(rollback_valid), 0);
    chk("rst_flush", int'(flush), 0);
    chk("rst_flush_done", int'(flush_done), 0);
    chk("rst_flushed_id", int'(flushed_instruction_ID), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_index", int'(alloc_index), 0);
    chk("rst_ready", int'(alloc_ready), 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rst_no_done%0d", k), int'(flush_done), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
